wb_decode_nport: RTL

//  Registered Wishbone classic 1-master -> NUM_SLAVES address decoder/interconnect.

---
 rtl/wb_decode_nport.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_decode_nport.sv
// Registered Wishbone classic 1-master to NUM_SLAVES decoder with unmapped-address
// error, bus-timeout watchdog and master-abort handling.
module wb_decode_nport #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic                             wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]          wbm_sel_i,
  input  logic                             wbm_stb_i,
  input  logic                             wbm_cyc_i,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic                             wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic                             wbs_we_o,
  output logic [SELECT_WIDTH-1:0]          wbs_sel_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
  output logic                             timeout_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic                    we_q, we_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   slv_q, slv_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    rty_q, rty_d;
  logic                    tmo_q, tmo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    req;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    s_ack, s_err, s_rty, s_any;
  logic [DATA_WIDTH-1:0]   s_dat;
  logic                    tmo_hit;

  assign req     = wbm_cyc_i & wbm_stb_i;
  assign s_ack   = wbs_ack_i[idx_q];
  assign s_err   = wbs_err_i[idx_q];
  assign s_rty   = wbs_rty_i[idx_q];
  assign s_any   = s_ack | s_err | s_rty;
  assign s_dat   = wbs_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end else begin
        hit     = hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = hit ? S_ACTIVE : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!wbm_cyc_i) begin
          state_d = S_IDLE;
        end else if (s_any || tmo_hit) begin
          state_d = S_RESP;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abort wins over a same-cycle slave response; error outranks ack and retry.
  always_comb begin
    adr_d  = adr_q;
    wdat_d = wdat_q;
    we_d   = we_q;
    sel_d  = sel_q;
    idx_d  = idx_q;
    rdat_d = rdat_q;
    slv_d  = '0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    rty_d  = 1'b0;
    tmo_d  = 1'b0;
    cnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d  = wbm_adr_i;
          wdat_d = wbm_dat_i;
          we_d   = wbm_we_i;
          sel_d  = wbm_sel_i;
          if (hit) begin
            idx_d        = hit_idx;
            slv_d[hit_idx] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          slv_d = '0;
        end
      end
      S_ACTIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!wbm_cyc_i) begin
          slv_d = '0;
        end else if (s_any) begin
          err_d = s_err;
          ack_d = s_ack & ~s_err;
          rty_d = s_rty & ~s_err & ~s_ack;
          if (!we_q) begin
            rdat_d = s_dat;
          end else begin
            rdat_d = rdat_q;
          end
        end else if (tmo_hit) begin
          err_d = 1'b1;
          tmo_d = 1'b1;
        end else begin
          slv_d = slv_q;
        end
      end
      S_RESP:  cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q  <= '0;
      wdat_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      idx_q  <= '0;
      rdat_q <= '0;
      slv_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rty_q  <= 1'b0;
      tmo_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      adr_q  <= adr_d;
      wdat_q <= wdat_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      idx_q  <= idx_d;
      rdat_q <= rdat_d;
      slv_q  <= slv_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      rty_q  <= rty_d;
      tmo_q  <= tmo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbm_rty_o = rty_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = wdat_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_cyc_o = slv_q;
  assign wbs_stb_o = slv_q;
  assign timeout_o = tmo_q;

endmodule
